// File: rtl/ball_engine.sv
// Pong ball engine: serve countdown, motion with wall/paddle bounces,
// miss detection, scoring and game-over handling.
module ball_engine #(
  parameter int B_SIZE       = 8,
  parameter int IX           = 320,
  parameter int IY           = 240,
  parameter int SPEED        = 2,
  parameter int D_WIDTH      = 639,
  parameter int D_HEIGHT     = 470,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        in_clock,
  input  logic        in_reset_n,
  input  logic        in_ani_stb,
  input  logic        in_animate,
  input  logic [11:0] in_l_x1,
  input  logic [11:0] in_l_x2,
  input  logic [11:0] in_l_y1,
  input  logic [11:0] in_l_y2,
  input  logic [11:0] in_r_x1,
  input  logic [11:0] in_r_x2,
  input  logic [11:0] in_r_y1,
  input  logic [11:0] in_r_y2,
  output logic [11:0] out_x1,
  output logic [11:0] out_x2,
  output logic [11:0] out_y1,
  output logic [11:0] out_y2,
  output logic [3:0]  out_score_l,
  output logic [3:0]  out_score_r,
  output logic        out_point,
  output logic [1:0]  out_state
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [11:0] BS_C      = 12'(B_SIZE);
  localparam logic [11:0] SPD_C     = 12'(SPEED);
  localparam logic [11:0] IX_C      = 12'(IX);
  localparam logic [11:0] IY_C      = 12'(IY);
  localparam logic [11:0] BOT_LIM_C = 12'(D_HEIGHT - SPEED);
  localparam logic [11:0] RGT_LIM_C = 12'(D_WIDTH - SPEED);
  localparam logic [11:0] CNT_C     = 12'(SERVE_FRAMES);
  localparam logic [3:0]  WIN_C     = 4'(WIN_SCORE);

  state_t      state_r, state_s;
  logic [11:0] x_r, x_s, y_r, y_s, cnt_r, cnt_s;
  logic        dx_r, dx_s, dy_r, dy_s;
  logic [3:0]  score_left_r, score_left_s, score_right_r, score_right_s;
  logic        scorer_left_r, scorer_left_s;
  logic        point_r, point_s;

  logic [11:0] x1_s, x2_s, y1_s, y2_s;
  logic [3:0]  inc_left_s, inc_right_s;
  logic        step_s, hit_l_s, hit_r_s, miss_l_s, miss_r_s, dx_res_s, dy_res_s;

  assign x1_s = x_r - BS_C;
  assign x2_s = x_r + BS_C;
  assign y1_s = y_r - BS_C;
  assign y2_s = y_r + BS_C;
  assign step_s = in_ani_stb & in_animate;
  assign inc_left_s  = score_left_r + 4'd1;
  assign inc_right_s = score_right_r + 4'd1;

  assign hit_l_s  = ~dx_r && (in_l_x1 <= x1_s) && (x1_s <= in_l_x2) &&
                    (y2_s >= in_l_y1) && (y1_s <= in_l_y2);
  assign hit_r_s  = dx_r && (in_r_x1 <= x2_s) && (x2_s <= in_r_x2) &&
                    (y2_s >= in_r_y1) && (y1_s <= in_r_y2);
  assign miss_l_s = ~dx_r && (x1_s <= SPD_C) && ~hit_l_s;
  assign miss_r_s = dx_r && (x2_s >= RGT_LIM_C) && ~hit_r_s;

  // Resolve the direction bits for this step (wall bounce and paddle hit are independent).
  always_comb begin
    dy_res_s = dy_r;
    dx_res_s = dx_r;
    if (~dy_r && (y1_s <= SPD_C)) begin
      dy_res_s = 1'b1;
    end else if (dy_r && (y2_s >= BOT_LIM_C)) begin
      dy_res_s = 1'b0;
    end else begin
      dy_res_s = dy_r;
    end
    if (hit_l_s) begin
      dx_res_s = 1'b1;
    end else if (hit_r_s) begin
      dx_res_s = 1'b0;
    end else begin
      dx_res_s = dx_r;
    end
  end

  // Next-state and datapath update for the game FSM.
  always_comb begin
    state_s       = state_r;
    x_s           = x_r;
    y_s           = y_r;
    dx_s          = dx_r;
    dy_s          = dy_r;
    cnt_s         = cnt_r;
    score_left_s  = score_left_r;
    score_right_s = score_right_r;
    scorer_left_s = scorer_left_r;
    point_s       = 1'b0;
    case (state_r)
      S_SERVE: begin
        if (step_s) begin
          if (cnt_r == 12'd0) begin
            state_s = S_PLAY;
          end else begin
            cnt_s = cnt_r - 12'd1;
          end
        end else begin
          state_s = S_SERVE;
        end
      end
      S_PLAY: begin
        if (step_s) begin
          dy_s = dy_res_s;
          if (miss_l_s) begin
            state_s       = S_POINT;
            scorer_left_s = 1'b0;
          end else if (miss_r_s) begin
            state_s       = S_POINT;
            scorer_left_s = 1'b1;
          end else begin
            dx_s = dx_res_s;
            x_s  = dx_res_s ? (x_r + SPD_C) : (x_r - SPD_C);
            y_s  = dy_res_s ? (y_r + SPD_C) : (y_r - SPD_C);
          end
        end else begin
          state_s = S_PLAY;
        end
      end
      S_POINT: begin
        // Serve toward the player who just conceded.
        point_s = 1'b1;
        x_s     = IX_C;
        y_s     = IY_C;
        cnt_s   = CNT_C;
        dx_s    = scorer_left_r;
        if (scorer_left_r) begin
          score_left_s = inc_left_s;
          state_s      = (inc_left_s == WIN_C) ? S_OVER : S_SERVE;
        end else begin
          score_right_s = inc_right_s;
          state_s       = (inc_right_s == WIN_C) ? S_OVER : S_SERVE;
        end
      end
      S_OVER: begin
        state_s = S_OVER;
      end
      default: begin
        state_s = S_SERVE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_r       <= S_SERVE;
      x_r           <= IX_C;
      y_r           <= IY_C;
      dx_r          <= 1'b1;
      dy_r          <= 1'b1;
      cnt_r         <= CNT_C;
      score_left_r  <= 4'd0;
      score_right_r <= 4'd0;
      scorer_left_r <= 1'b0;
      point_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      x_r           <= x_s;
      y_r           <= y_s;
      dx_r          <= dx_s;
      dy_r          <= dy_s;
      cnt_r         <= cnt_s;
      score_left_r  <= score_left_s;
      score_right_r <= score_right_s;
      scorer_left_r <= scorer_left_s;
      point_r       <= point_s;
    end
  end

  assign out_x1      = x1_s;
  assign out_x2      = x2_s;
  assign out_y1      = y1_s;
  assign out_y2      = y2_s;
  assign out_score_l = score_left_r;
  assign out_score_r = score_right_r;
  assign out_point   = point_r;
  assign out_state   = state_r;

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a reference model predicts every cycle,
// directed scenarios add fixed-value checks at the interesting moments.
module tb_ball_engine;

  typedef struct packed {
    logic [11:0] x1;
    logic [11:0] x2;
    logic [11:0] y1;
    logic [11:0] y2;
    logic [1:0]  st;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        pt;
  } exp_t;

  logic        in_clock = 1'b0;
  logic        in_reset_n, in_ani_stb, in_animate;
  logic [11:0] l_x1, l_x2, l_y1, l_y2, r_x1, r_x2, r_y1, r_y2;
  logic [11:0] out_x1, out_x2, out_y1, out_y2;
  logic [3:0]  out_score_l, out_score_r;
  logic        out_point;
  logic [1:0]  out_state;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  int   m_x, m_y, m_cnt, m_st, m_sl, m_sr;
  logic m_dx, m_dy, m_scl, m_pt;
  logic l_avoid, r_avoid;

  ball_engine #(
    .B_SIZE(8), .IX(320), .IY(240), .SPEED(2), .D_WIDTH(639),
    .D_HEIGHT(470), .SERVE_FRAMES(2), .WIN_SCORE(9)
  ) dut (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_ani_stb(in_ani_stb),
    .in_animate(in_animate),
    .in_l_x1(l_x1), .in_l_x2(l_x2), .in_l_y1(l_y1), .in_l_y2(l_y2),
    .in_r_x1(r_x1), .in_r_x2(r_x2), .in_r_y1(r_y1), .in_r_y2(r_y2),
    .out_x1(out_x1), .out_x2(out_x2), .out_y1(out_y1), .out_y2(out_y2),
    .out_score_l(out_score_l), .out_score_r(out_score_r),
    .out_point(out_point), .out_state(out_state)
  );

  always #5 in_clock = ~in_clock;

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dx = 1'b1; m_dy = 1'b1; m_cnt = 2;
    m_st = 0; m_sl = 0; m_sr = 0; m_scl = 1'b0; m_pt = 1'b0;
  endtask

  task automatic model_next(input logic step);
    int   x1, x2, y1, y2;
    logic ndx, ndy, lh, rh;
    x1 = m_x - 8; x2 = m_x + 8; y1 = m_y - 8; y2 = m_y + 8;
    m_pt = 1'b0;
    case (m_st)
      0: if (step) begin
        if (m_cnt == 0) m_st = 1;
        else m_cnt = m_cnt - 1;
      end
      1: if (step) begin
        ndy = m_dy;
        if (!m_dy && y1 <= 2) ndy = 1'b1;
        else if (m_dy && y2 >= 468) ndy = 1'b0;
        lh = !m_dx && int'(l_x1) <= x1 && x1 <= int'(l_x2) && y2 >= int'(l_y1) && y1 <= int'(l_y2);
        rh = m_dx && int'(r_x1) <= x2 && x2 <= int'(r_x2) && y2 >= int'(r_y1) && y1 <= int'(r_y2);
        ndx = lh ? 1'b1 : (rh ? 1'b0 : m_dx);
        m_dy = ndy;
        if (!m_dx && x1 <= 2 && !lh) begin
          m_st = 2; m_scl = 1'b0;
        end else if (m_dx && x2 >= 637 && !rh) begin
          m_st = 2; m_scl = 1'b1;
        end else begin
          m_dx = ndx;
          m_x = ndx ? m_x + 2 : m_x - 2;
          m_y = ndy ? m_y + 2 : m_y - 2;
        end
      end
      2: begin
        m_pt = 1'b1; m_x = 320; m_y = 240; m_dx = m_scl; m_cnt = 2;
        if (m_scl) begin m_sl = m_sl + 1; m_st = (m_sl == 9) ? 3 : 0; end
        else begin m_sr = m_sr + 1; m_st = (m_sr == 9) ? 3 : 0; end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x1 = 12'(m_x - 8); e.x2 = 12'(m_x + 8);
    e.y1 = 12'(m_y - 8); e.y2 = 12'(m_y + 8);
    e.st = 2'(m_st); e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.pt = m_pt;
    return e;
  endfunction

  // Bars either cover the full height or dodge the ball vertically to force a miss.
  task automatic drive_bars();
    l_x1 = 12'd0;   l_x2 = 12'd20;
    r_x1 = 12'd619; r_x2 = 12'd639;
    if (l_avoid) begin
      if (m_y - 8 >= 200) begin l_y1 = 12'd0;   l_y2 = 12'd100; end
      else                begin l_y1 = 12'd360; l_y2 = 12'd470; end
    end else begin l_y1 = 12'd0; l_y2 = 12'd470; end
    if (r_avoid) begin
      if (m_y - 8 >= 200) begin r_y1 = 12'd0;   r_y2 = 12'd100; end
      else                begin r_y1 = 12'd360; r_y2 = 12'd470; end
    end else begin r_y1 = 12'd0; r_y2 = 12'd470; end
  endtask

  task automatic tick(input logic stb);
    exp_t e, a;
    in_ani_stb = stb;
    drive_bars();
    model_next(stb && in_animate);
    sb.push_back(model_out());
    @(posedge in_clock); #1;
    e = sb.pop_front();
    a.x1 = out_x1; a.x2 = out_x2; a.y1 = out_y1; a.y2 = out_y2;
    a.st = out_state; a.sl = out_score_l; a.sr = out_score_r; a.pt = out_point;
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scoreboard @%0t: got x1=%0d x2=%0d y1=%0d y2=%0d st=%0d sl=%0d sr=%0d pt=%0d, expected x1=%0d x2=%0d y1=%0d y2=%0d st=%0d sl=%0d sr=%0d pt=%0d",
               $time, a.x1, a.x2, a.y1, a.y2, a.st, a.sl, a.sr, a.pt,
               e.x1, e.x2, e.y1, e.y2, e.st, e.sl, e.sr, e.pt);
    end
  endtask

  task automatic strobe();
    tick(1'b1);
    tick(1'b0);
  endtask

  task automatic test_reset();
    in_reset_n = 1'b0; in_ani_stb = 1'b1; in_animate = 1'b1;
    l_avoid = 1'b0; r_avoid = 1'b0;
    model_reset();
    drive_bars();
    repeat (3) @(posedge in_clock);
    #1;
    n_vec++;
    if ({out_x1, out_x2, out_y1, out_y2} !== {12'd312, 12'd328, 12'd232, 12'd248}) begin
      n_bad++; $display("FAIL reset_edges: got %0d/%0d/%0d/%0d expected 312/328/232/248", out_x1, out_x2, out_y1, out_y2);
    end
    n_vec++;
    if ({out_state, out_score_l, out_score_r, out_point} !== {2'd0, 4'd0, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_status: got st=%0d sl=%0d sr=%0d pt=%0d expected 0/0/0/0", out_state, out_score_l, out_score_r, out_point);
    end
    in_ani_stb = 1'b0;
    @(negedge in_clock);
    in_reset_n = 1'b1;
    @(posedge in_clock); #1;
  endtask

  task automatic test_serve();
    in_animate = 1'b0;
    repeat (3) strobe();
    n_vec++;
    if (out_state !== 2'd0) begin n_bad++; $display("FAIL animate_low_state: got %0d expected 0", out_state); end
    in_animate = 1'b1;
    repeat (3) strobe();
    n_vec++;
    if ({out_state, out_x1, out_y1} !== {2'd1, 12'd312, 12'd232}) begin
      n_bad++; $display("FAIL serve_to_play: got st=%0d x1=%0d y1=%0d expected 1/312/232", out_state, out_x1, out_y1);
    end
    strobe();
    n_vec++;
    if ({out_x1, out_y1} !== {12'd314, 12'd234}) begin
      n_bad++; $display("FAIL first_move: got x1=%0d y1=%0d expected 314/234", out_x1, out_y1);
    end
  endtask

  task automatic test_wall_bounce();
    int n = 0;
    while (!(m_st == 1 && !m_dy && m_y - 8 == 2) && n < 2000) begin strobe(); n++; end
    n_vec++;
    if (n >= 2000) begin n_bad++; $display("FAIL wall_wait: got timeout expected top approach"); end
    strobe();
    n_vec++;
    if (out_y1 !== 12'd4) begin n_bad++; $display("FAIL wall_bounce_y1: got %0d expected 4", out_y1); end
    strobe();
    n_vec++;
    if (out_y1 !== 12'd6) begin n_bad++; $display("FAIL wall_bounce_dy: got y1=%0d expected 6", out_y1); end
  endtask

  task automatic test_paddle_hit();
    int n = 0;
    while (!(m_st == 1 && !m_dx && m_x - 8 == 20) && n < 2000) begin strobe(); n++; end
    n_vec++;
    if (n >= 2000) begin n_bad++; $display("FAIL paddle_wait: got timeout expected left approach"); end
    strobe();
    n_vec++;
    if ({out_x1, out_point, out_state} !== {12'd22, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL paddle_hit: got x1=%0d pt=%0d st=%0d expected 22/0/1", out_x1, out_point, out_state);
    end
  endtask

  task automatic test_left_miss();
    int n = 0;
    l_avoid = 1'b1;
    while (n < 4000) begin
      tick(1'b1);
      if (m_st == 2) break;
      tick(1'b0);
      n++;
    end
    n_vec++;
    if ({out_state, out_point, out_x1} !== {2'd2, 1'b0, 12'd2}) begin
      n_bad++; $display("FAIL miss_enter_point: got st=%0d pt=%0d x1=%0d expected 2/0/2", out_state, out_point, out_x1);
    end
    tick(1'b0);
    n_vec++;
    if ({out_point, out_score_r, out_score_l, out_state} !== {1'b1, 4'd1, 4'd0, 2'd0}) begin
      n_bad++; $display("FAIL miss_point_pulse: got pt=%0d sr=%0d sl=%0d st=%0d expected 1/1/0/0", out_point, out_score_r, out_score_l, out_state);
    end
    n_vec++;
    if ({out_x1, out_y1} !== {12'd312, 12'd232}) begin
      n_bad++; $display("FAIL miss_recentre: got x1=%0d y1=%0d expected 312/232", out_x1, out_y1);
    end
    tick(1'b0);
    n_vec++;
    if (out_point !== 1'b0) begin n_bad++; $display("FAIL miss_pulse_width: got %0d expected 0", out_point); end
    l_avoid = 1'b0;
    repeat (4) strobe();
    n_vec++;
    if (out_x1 !== 12'd310) begin n_bad++; $display("FAIL serve_toward_left: got x1=%0d expected 310", out_x1); end
  endtask

  task automatic test_async_reset();
    @(negedge in_clock); #1;
    in_reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_x1, out_x2, out_y1, out_y2} !== {12'd312, 12'd328, 12'd232, 12'd248}) begin
      n_bad++; $display("FAIL async_reset_edges: got %0d/%0d/%0d/%0d expected 312/328/232/248", out_x1, out_x2, out_y1, out_y2);
    end
    n_vec++;
    if ({out_state, out_score_l, out_score_r, out_point} !== {2'd0, 4'd0, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL async_reset_status: got st=%0d sl=%0d sr=%0d pt=%0d expected 0/0/0/0", out_state, out_score_l, out_score_r, out_point);
    end
    #1;
    in_reset_n = 1'b1;
    model_reset();
    @(posedge in_clock); #1;
  endtask

  task automatic test_game_over();
    int n = 0;
    r_avoid = 1'b1;
    while (n < 6000) begin
      tick(1'b1);
      if (m_st == 2 && m_sl == 8) break;
      tick(1'b0);
      n++;
    end
    n_vec++;
    if ({out_state, out_score_l} !== {2'd2, 4'd8}) begin
      n_bad++; $display("FAIL pre_win: got st=%0d sl=%0d expected 2/8", out_state, out_score_l);
    end
    tick(1'b0);
    n_vec++;
    if ({out_score_l, out_state, out_point} !== {4'd9, 2'd3, 1'b1}) begin
      n_bad++; $display("FAIL game_over: got sl=%0d st=%0d pt=%0d expected 9/3/1", out_score_l, out_state, out_point);
    end
    for (int i = 0; i < 10; i++) begin
      strobe();
      n_vec++;
      if ({out_x1, out_y1, out_state, out_score_l} !== {12'd312, 12'd232, 2'd3, 4'd9}) begin
        n_bad++; $display("FAIL over_frozen[%0d]: got x1=%0d y1=%0d st=%0d sl=%0d expected 312/232/3/9", i, out_x1, out_y1, out_state, out_score_l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_wall_bounce();
    test_paddle_hit();
    test_left_miss();
    test_async_reset();
    test_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter B_SIZE, default 8, half ball size in pixels.
REQ-002 SHALL have parameter IX, default 320, ball-centre serve x.
REQ-003 SHALL have parameter IY, default 240, ball-centre serve y.
REQ-004 SHALL have parameter SPEED, default 2, pixels moved per axis per animation strobe.
REQ-005 SHALL have parameter D_WIDTH, default 639, display width.
REQ-006 SHALL have parameter D_HEIGHT, default 470, display height.
REQ-007 SHALL have parameter SERVE_FRAMES, default 60, serve-delay strobes.
REQ-008 SHALL have parameter WIN_SCORE, default 9, winning score.
REQ-009 SHALL have port in_clock, input, 1 bit, base clock; the block uses one clock, and all state changes on its rising edge.
REQ-010 SHALL have port in_reset_n, input, 1 bit, reset; asynchronous and active-low.
REQ-011 SHALL have port in_ani_stb, input, 1 bit, one-cycle animation strobe per frame.
REQ-012 SHALL have port in_animate, input, 1 bit; motion and countdown are enabled only while this is high.
REQ-013 SHALL have ports in_l_x1, in_l_x2, in_l_y1, in_l_y2, input, 12 bits each, left bar left/right/top/bottom edges.
REQ-014 SHALL have ports in_r_x1, in_r_x2, in_r_y1, in_r_y2, input, 12 bits each, right bar edges, same layout.
REQ-015 SHALL have ports out_x1, out_x2, out_y1, out_y2, output, 12 bits each, ball edges, equal to centre -/+ B_SIZE (combinational).
REQ-016 SHALL have ports out_score_l and out_score_r, output, 4 bits each, player scores.
REQ-017 SHALL have port out_point, output, 1 bit, one-cycle pulse when a point is awarded.
REQ-018 SHALL have port out_state, output, 2 bits; SERVE=0, PLAY=1, POINT=2, OVER=3.

Function
REQ-019 SHALL hold internal registers: 12-bit centre x and y; direction bits dx (1=right) and dy (1=down); serve counter; state.
REQ-020 SHALL treat a "step" as any cycle with in_ani_stb=1 and in_animate=1; nothing except the POINT→next transition occurs outside steps.
REQ-021 In SERVE, SHALL on each step: if counter==0, go to PLAY with no motion that step; otherwise decrement the counter.
REQ-022 In PLAY, SHALL on each step first resolve direction, then move x and y by SPEED in the resolved direction.
REQ-023 SHALL set dy=1 when moving up and out_y1 <= SPEED (top bounce).
REQ-024 SHALL set dy=0 when moving down and out_y2 >= D_HEIGHT-SPEED (bottom bounce).
REQ-025 Left paddle hit: when dx=0, in_l_x1 <= out_x1 <= in_l_x2, out_y2 >= in_l_y1 and out_y1 <= in_l_y2, SHALL set dx=1.
REQ-026 Right paddle hit: when dx=1, in_r_x1 <= out_x2 <= in_r_x2, with the same y overlap against the right bar, SHALL set dx=0.
REQ-027 Left miss: when dx=0, out_x1 <= SPEED and no left hit, SHALL enter POINT with the right player as scorer and no motion.
REQ-028 Right miss: when dx=1, out_x2 >= D_WIDTH-SPEED and no right hit, SHALL enter POINT with the left player as scorer and no motion.
REQ-029 A paddle hit SHALL take priority over a miss in the same step; a wall bounce and a paddle hit in the same step SHALL both apply.
REQ-030 In POINT, SHALL on the next clock, strobe not required:
- increment the scorer's score;
- pulse out_point high for exactly that cycle;
- recentre to IX,IY;
- set dx toward the conceding player and keep dy;
- load the counter with SERVE_FRAMES.
REQ-031 On that same clock, SHALL enter OVER if the incremented score equals WIN_SCORE, else SERVE.
REQ-032 OVER SHALL be absorbing: ball held at centre, scores frozen, until reset.
REQ-033 With in_animate low, SHALL freeze all state except a pending POINT→next transition.
REQ-034 All arithmetic SHALL be 12-bit unsigned; the boundary rules keep the ball edges within 0..D_WIDTH and 0..D_HEIGHT, so no wrap-around occurs.

Reset
REQ-035 SHALL, while in_reset_n=0, asynchronously force x=IX, y=IY, dx=1, dy=1, both scores 0, out_point=0, state SERVE, counter=SERVE_FRAMES.
REQ-036 SHALL apply reset mid-operation (including in POINT or OVER) immediately, with no score update and no out_point pulse.

Verification
REQ-037 Serve: SERVE_FRAMES=2, animate high -> out_state=1 after the 3rd strobe; out_x1=312, out_y1=232 unchanged until the 4th strobe, then 314/234.
REQ-038 Wall bounce: ball moving up with out_y1=2 -> after the next strobe out_y1=4 and dy=1.
REQ-039 Paddle hit: dx=0, left bar x 0..20 and y 150..330, ball out_x1=20 at y=240 -> after the strobe out_x1=22 and no out_point.
REQ-040 Left miss: left bar moved to y 0..100, ball out_x1=2 moving left -> state POINT, then a 1-cycle out_point, out_score_r=1, ball at 320,240, dx=0, state SERVE.
REQ-041 Game over: out_score_l=8 and a right miss -> out_score_l=9, out_state=3, and no further motion over 10 strobes.
REQ-042 Async reset: in_reset_n pulsed low between clock edges during PLAY -> outputs return to reset values (REQ-035) before the next clock edge.
